// File: rtl/flash_rd_arbiter_if.sv
// Request/acknowledge bus shared by the two read ports of flash_rd_arbiter.
// master: the requesting side; slave: the arbiter.
interface flash_rd_arbiter_if;
    logic        i_req0;
    logic [23:0] i_adr0;
    logic        o_ack0;
    logic        i_req1;
    logic [23:0] i_adr1;
    logic        o_ack1;
    logic [31:0] o_rdata;
    logic        o_busy;

    modport master (
        output i_req0, i_adr0, i_req1, i_adr1,
        input  o_ack0, o_ack1, o_rdata, o_busy
    );

    modport slave (
        input  i_req0, i_adr0, i_req1, i_adr1,
        output o_ack0, o_ack1, o_rdata, o_busy
    );
endinterface

// File: rtl/flash_rd_arbiter.sv
// Two-port round-robin arbiter issuing SPI flash word reads (mode 0, 0x03 read).
// Define FLASH_FAST_READ_EN to use 0x0B with 8 dummy clocks instead.
module flash_rd_arbiter #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    flash_rd_arbiter_if.slave   bus,
    output logic                o_flash_ss,
    output logic                o_flash_sck,
    output logic                o_flash_mosi,
    input  logic                i_flash_miso
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] RD_CMD = 8'h0B;
`else
    localparam logic [7:0] RD_CMD = 8'h03;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP} state_t;

    state_t      state, state_next;
    logic [7:0]  div_cnt;
    logic [7:0]  gap_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  last_bit;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [31:0] rdata;
    logic        ack0, ack1;
    logic        ss, sck;
    logic        grant, ptr, win, any_req;
    logic        shifting, tick, rise, fall, phase_end;

    always_comb begin
        any_req  = bus.i_req0 | bus.i_req1;
        win      = (bus.i_req0 && bus.i_req1) ? ptr : bus.i_req1;
        shifting = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
        tick     = (div_cnt == 8'(CLK_DIV - 1));
        rise     = shifting && tick && !sck;
        fall     = shifting && tick && sck;
        case (state)
            CMD:     last_bit = 5'd7;
            ADDR:    last_bit = 5'd23;
            DUMMY:   last_bit = 5'd7;
            DATA:    last_bit = 5'd31;
            default: last_bit = 5'd0;
        endcase
        phase_end = fall && (bit_cnt == last_bit);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = CMD;
            CMD:   if (phase_end) state_next = ADDR;
`ifdef FLASH_FAST_READ_EN
            ADDR:  if (phase_end) state_next = DUMMY;
`else
            ADDR:  if (phase_end) state_next = DATA;
`endif
            DUMMY: if (phase_end) state_next = DATA;
            DATA:  if (phase_end) state_next = DONE;
            DONE:  state_next = GAP;
            GAP:   if (gap_cnt == 8'(CS_GAP - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Command and address form one 32-bit shift word; MOSI is its MSB and
    // zeros shift in behind it, so MOSI is 0 during dummy, data and idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ss      <= 1'b1;
            sck     <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            rdata   <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            grant   <= 1'b0;
            ptr     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= win;
                        tx      <= {RD_CMD, win ? bus.i_adr1 : bus.i_adr0};
                        ss      <= 1'b0;
                        sck     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (rise && state == DATA) rx <= {rx[30:0], i_flash_miso};
                        if (fall) begin
                            tx      <= {tx[30:0], 1'b0};
                            bit_cnt <= phase_end ? 5'd0 : bit_cnt + 5'd1;
                        end
                        // Flash bytes arrive in address order; swap to little-endian.
                        if (phase_end && state == DATA) begin
                            rdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                            ack0  <= ~grant;
                            ack1  <= grant;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    ss      <= 1'b1;
                    ptr     <= ~grant;
                    gap_cnt <= '0;
                end
                GAP: gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign o_flash_ss   = ss;
    assign o_flash_sck  = sck;
    assign o_flash_mosi = tx[31];
    assign bus.o_ack0   = ack0;
    assign bus.o_ack1   = ack1;
    assign bus.o_rdata  = rdata;
    assign bus.o_busy   = (state != IDLE);

endmodule
